// File: rtl/mcu_exec_core.sv
// rtl/mcu_exec_core.sv - multi-cycle MCU execution core with internal register-file memory
module mcu_exec_core #(
  parameter int OP_SZ  = 32,
  parameter int MEM_SZ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_code,
  input  logic [MEM_SZ-1:0] op0,
  input  logic [MEM_SZ-1:0] op1,
  input  logic [MEM_SZ-1:0] op2,
  input  logic [OP_SZ-1:0]  wdata,
  output logic [OP_SZ-1:0]  out,
  output logic              done,
  output logic              carry,
  output logic              zero,
  output logic              err
);

  localparam int DEPTH = 2 ** MEM_SZ;
  localparam int SHW   = $clog2(OP_SZ);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         opc_q, opc_d;
  logic [MEM_SZ-1:0]  src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic [OP_SZ-1:0]   wdata_q, wdata_d;
  logic [OP_SZ-1:0]   a_q, a_d, b_q, b_d;
  logic [OP_SZ-1:0]   out_q, out_d;
  logic               carry_q, carry_d, zero_q, zero_d, err_q, err_d;
  logic [OP_SZ-1:0]   mem_q [DEPTH];
  logic [OP_SZ-1:0]   mem_d [DEPTH];

  logic [OP_SZ:0]     sum, diff;
  logic [OP_SZ-1:0]   res;
  logic               res_c, res_err, res_wr;

  // ALU: operates only on the registered operands and captured instruction
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    res     = '0;
    res_c   = 1'b0;
    res_err = 1'b0;
    res_wr  = 1'b1;
    case (opc_q)
      4'd0: begin res = sum[OP_SZ-1:0];  res_c = sum[OP_SZ];  end
      4'd1: begin res = diff[OP_SZ-1:0]; res_c = diff[OP_SZ]; end
      4'd2: res = a_q << b_q[SHW-1:0];
      4'd3: res = a_q >> b_q[SHW-1:0];
      4'd4: res = a_q & b_q;
      4'd5: res = a_q | b_q;
      4'd6: res = a_q ^ b_q;
      4'd7: res = ~a_q;
      4'd8: res = wdata_q;
      4'd9: begin res = a_q; res_wr = 1'b0; end
      default: begin res_err = 1'b1; res_wr = 1'b0; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    dst_d    = dst_q;
    wdata_d  = wdata_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    mem_d    = mem_q;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opc_d   = op_code;
          src_a_d = op0;
          dst_d   = op1;
          src_b_d = op2;
          wdata_d = wdata;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        a_d     = mem_q[src_a_q];
        b_d     = mem_q[src_b_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        out_d   = res;
        carry_d = res_c;
        zero_d  = (res == '0);
        err_d   = res_err;
        if (res_wr) mem_d[dst_q] = res;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      wdata_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      dst_q   <= dst_d;
      wdata_q <= wdata_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign zero  = zero_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mcu_exec_core.sv
// tb/tb_mcu_exec_core.sv - directed table-driven bench for mcu_exec_core
module tb_mcu_exec_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op_code = '0;
  logic [3:0]  op0 = '0, op1 = '0, op2 = '0;
  logic [31:0] wdata = '0;
  logic [31:0] out;
  logic        done, carry, zero, err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;

  mcu_exec_core #(.OP_SZ(32), .MEM_SZ(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .op0(op0), .op1(op1), .op2(op2), .wdata(wdata),
    .out(out), .done(done), .carry(carry), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  a0;
    logic [3:0]  d;
    logic [3:0]  a2;
    logic [31:0] wd;
    logic [31:0] eo;
    logic        ec;
    logic        ez;
    logic        ee;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic [3:0] op, logic [3:0] a0, logic [3:0] d, logic [3:0] a2,
                              logic [31:0] wd, logic [31:0] eo, logic ec, logic ez, logic ee);
    vec_t v;
    v.op = op; v.a0 = a0; v.d = d; v.a2 = a2; v.wd = wd;
    v.eo = eo; v.ec = ec; v.ez = ez; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    op_code = v.op; op0 = v.a0; op1 = v.d; op2 = v.a2; wdata = v.wd;
  endtask

  task automatic scramble();
    op_code = 4'hF; op0 = 4'($urandom); op1 = 4'($urandom); op2 = 4'($urandom);
    wdata = $urandom;
  endtask

  // One full handshake; called at a negedge, returns at the negedge after DONE
  task automatic run(input vec_t v, input string name);
    int n;
    drive(v);
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk({name, "_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
    n = 1;
    while (done !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk({name, "_latency"}, n, 32'd3);
    chk({name, "_out"}, out, v.eo);
    chk({name, "_carry"}, {31'd0, carry}, {31'd0, v.ec});
    chk({name, "_zero"}, {31'd0, zero}, {31'd0, v.ez});
    chk({name, "_err"}, {31'd0, err}, {31'd0, v.ee});
    @(negedge clk);
    chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int c_prev, c_now, d0;
    vec_t bb[3];

    tv.push_back(mk(4'd8, 4'd0, 4'd1, 4'd0, 32'd200, 32'd200, 0, 0, 0));
    tv.push_back(mk(4'd8, 4'd0, 4'd2, 4'd0, 32'd220, 32'd220, 0, 0, 0));
    tv.push_back(mk(4'd0, 4'd1, 4'd3, 4'd2, 32'd0, 32'd420, 0, 0, 0));
    tv.push_back(mk(4'd9, 4'd3, 4'd7, 4'd0, 32'd0, 32'd420, 0, 0, 0));
    tv.push_back(mk(4'd5, 4'd1, 4'd4, 4'd2, 32'd0, 32'd220, 0, 0, 0));
    tv.push_back(mk(4'd1, 4'd1, 4'd8, 4'd2, 32'd0, 32'hFFFF_FFEC, 1, 0, 0));
    tv.push_back(mk(4'd1, 4'd2, 4'd9, 4'd1, 32'd0, 32'd20, 0, 0, 0));
    tv.push_back(mk(4'd8, 4'd0, 4'd5, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0));
    tv.push_back(mk(4'd8, 4'd0, 4'd6, 4'd0, 32'd1, 32'd1, 0, 0, 0));
    tv.push_back(mk(4'd0, 4'd5, 4'd10, 4'd6, 32'd0, 32'd0, 1, 1, 0));
    tv.push_back(mk(4'd8, 4'd0, 4'd11, 4'd0, 32'd31, 32'd31, 0, 0, 0));
    tv.push_back(mk(4'd2, 4'd6, 4'd12, 4'd11, 32'd0, 32'h8000_0000, 0, 0, 0));
    tv.push_back(mk(4'd8, 4'd0, 4'd13, 4'd0, 32'd35, 32'd35, 0, 0, 0));
    tv.push_back(mk(4'd3, 4'd12, 4'd14, 4'd13, 32'd0, 32'h1000_0000, 0, 0, 0));
    tv.push_back(mk(4'd12, 4'd5, 4'd1, 4'd6, 32'd77, 32'd0, 0, 1, 1));
    tv.push_back(mk(4'd9, 4'd1, 4'd0, 4'd0, 32'd0, 32'd200, 0, 0, 0));
    tv.push_back(mk(4'd9, 4'd7, 4'd0, 4'd0, 32'd0, 32'd0, 0, 1, 0));
    tv.push_back(mk(4'd4, 4'd1, 4'd15, 4'd2, 32'd0, 32'd200, 0, 0, 0));
    tv.push_back(mk(4'd6, 4'd1, 4'd15, 4'd2, 32'd0, 32'd20, 0, 0, 0));
    tv.push_back(mk(4'd7, 4'd5, 4'd15, 4'd0, 32'd0, 32'd0, 0, 1, 0));

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_out", out, 32'd0);
    chk("rst_flags", {28'd0, done, carry, zero, err}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    foreach (tv[i]) run(tv[i], $sformatf("vec%0d", i));

    // Back-to-back with in_valid held high; second/third read the previous result
    bb[0] = mk(4'd8, 4'd0, 4'd7, 4'd0, 32'h55, 32'h55, 0, 0, 0);
    bb[1] = mk(4'd0, 4'd7, 4'd8, 4'd7, 32'd0, 32'hAA, 0, 0, 0);
    bb[2] = mk(4'd6, 4'd8, 4'd9, 4'd7, 32'd0, 32'hFF, 0, 0, 0);
    d0 = done_cnt;
    c_prev = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(bb[i]);
      chk($sformatf("bb%0d_ready", i), {31'd0, in_ready}, 32'd1);
      for (int j = 1; j <= 3; j++) begin
        @(negedge clk);
        chk($sformatf("bb%0d_busy%0d", i, j), {31'd0, in_ready}, 32'd0);
        chk($sformatf("bb%0d_done%0d", i, j), {31'd0, done}, (j == 3) ? 32'd1 : 32'd0);
      end
      c_now = cyc;
      chk($sformatf("bb%0d_out", i), out, bb[i].eo);
      if (i > 0) chk($sformatf("bb%0d_spacing", i), c_now - c_prev, 32'd4);
      c_prev = c_now;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("bb_done_count", done_cnt - d0, 32'd3);

    // Aliasing: all three addresses equal
    run(mk(4'd0, 4'd2, 4'd2, 4'd2, 32'd0, 32'd440, 0, 0, 0), "alias_add");
    run(mk(4'd9, 4'd2, 4'd0, 4'd0, 32'd0, 32'd440, 0, 0, 0), "alias_rd");

    // Reset during EXEC of an ADD
    d0 = done_cnt;
    drive(mk(4'd0, 4'd1, 4'd3, 4'd2, 32'd0, 32'd0, 0, 0, 0));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out", out, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_no_done", done_cnt - d0, 32'd0);
    run(mk(4'd9, 4'd3, 4'd0, 4'd0, 32'd0, 32'd0, 0, 1, 0), "post_rst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
